// File: rtl/fifo_burst_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_packer_if
//  Purpose  : Bundles the prefetch-FIFO read handshake and the packed output
//             stream of fifo_burst_packer.
//  Signals  : fifo_rd_data/fifo_rd_vld/fifo_rd_en  - FIFO head and pop request
//             out_data/out_keep/out_last/out_valid/out_ready - word stream
//  Modports : master - packer side (pops FIFO, sources the stream)
//             slave  - environment side (FIFO and stream sink)
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_burst_packer_if #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
);
  logic [DATA_W-1:0]      fifo_rd_data;
  logic                   fifo_rd_vld;
  logic                   fifo_rd_en;
  logic [DATA_W*PACK-1:0] out_data;
  logic [PACK-1:0]        out_keep;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  fifo_rd_data, fifo_rd_vld, out_ready,
    output fifo_rd_en, out_data, out_keep, out_last, out_valid
  );

  modport slave (
    output fifo_rd_data, fifo_rd_vld, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_last, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_burst_packer
//  Purpose  : Pops a commanded number of entries from the prefetch FIFO and
//             packs them little-endian into PACK-entry words carrying a
//             byte-keep mask and an end-of-burst marker.
//  Ports    : rd_clk, rd_rst     - clock, asynchronous active-high reset
//             start, burst_len   - burst command (sampled only when idle)
//             abort              - synchronous cancel of the running burst
//             busy, done         - status (done is a one-cycle pulse)
//             bus (master)       - FIFO read handshake and output stream
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_packer #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4,
  parameter int LEN_W  = 12
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  fifo_burst_packer_if.master bus
);

  localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FILL  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(PACK - 1);
  localparam logic [LEN_W-1:0] c_REM_ONE  = LEN_W'(1);

  logic [1:0]             r_state;
  logic [LEN_W-1:0]       r_rem;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_W*PACK-1:0] r_acc;
  logic [PACK-1:0]        r_acc_keep;
  logic                   r_acc_last;
  logic                   r_acc_full;
  logic [DATA_W*PACK-1:0] r_out_data;
  logic [PACK-1:0]        r_out_keep;
  logic                   r_out_last;
  logic                   r_out_valid;
  logic                   r_done;

  logic w_rd_en;
  logic w_pop;
  logic w_pop_last;
  logic w_word_end;
  logic w_load;
  logic w_xfer;

  // A full accumulator whose output slot is empty is guaranteed to unload on
  // this edge, so the next pop may land in slot 0 in the same cycle. This keeps
  // one pop per cycle under free-flowing output while staying a pure register
  // decode (no path from fifo_rd_vld or out_ready).
  assign w_rd_en    = (r_state == c_FILL) & (~r_acc_full | ~r_out_valid);
  assign w_pop      = w_rd_en & bus.fifo_rd_vld;
  assign w_pop_last = w_pop & (r_rem == c_REM_ONE);
  assign w_word_end = w_pop & ((r_idx == c_LAST_IDX) | (r_rem == c_REM_ONE));
  assign w_load     = r_acc_full & (~r_out_valid | bus.out_ready);
  assign w_xfer     = r_out_valid & bus.out_ready;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state     <= c_IDLE;
      r_rem       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_acc_keep  <= '0;
      r_acc_last  <= 1'b0;
      r_acc_full  <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != c_IDLE) && abort) begin
        // Cancel: anything popped so far is dropped, no completion pulse.
        r_state     <= c_IDLE;
        r_rem       <= '0;
        r_idx       <= '0;
        r_acc       <= '0;
        r_acc_keep  <= '0;
        r_acc_last  <= 1'b0;
        r_acc_full  <= 1'b0;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (start) begin
              if (burst_len != '0) begin
                r_state <= c_FILL;
                r_rem   <= burst_len;
                r_idx   <= '0;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          c_FILL: begin
            if (w_pop_last) begin
              r_state <= c_DRAIN;
            end
          end
          c_DRAIN: begin
            if (w_xfer && r_out_last) begin
              r_state <= c_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= c_IDLE;
        endcase

        // Unloading wipes the accumulator so a short final word carries zeros
        // in its unkept slots. A same-cycle pop below overrides slot 0.
        if (w_load) begin
          r_acc      <= '0;
          r_acc_keep <= '0;
          r_acc_last <= 1'b0;
          r_acc_full <= 1'b0;
        end

        if (w_pop) begin
          for (int k = 0; k < PACK; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_acc[k*DATA_W +: DATA_W] <= bus.fifo_rd_data;
              r_acc_keep[k]             <= 1'b1;
            end
          end
          r_rem <= r_rem - c_REM_ONE;
          if (w_word_end) begin
            r_acc_full <= 1'b1;
            r_idx      <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
          if (r_rem == c_REM_ONE) begin
            r_acc_last <= 1'b1;
          end
        end

        if (w_load) begin
          r_out_data  <= r_acc;
          r_out_keep  <= r_acc_keep;
          r_out_last  <= r_acc_last;
          r_out_valid <= 1'b1;
        end else if (w_xfer) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign busy           = (r_state != c_IDLE);
  assign done           = r_done;
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_data   = r_out_data;
  assign bus.out_keep   = r_out_keep;
  assign bus.out_last   = r_out_last;
  assign bus.out_valid  = r_out_valid;

endmodule
`default_nettype wire
